// File: rtl/cpu_bus_ctrl_pkg.sv
// cpu_bus_ctrl shared types and defaults.
// State encodings, window defaults and the slow-window decode helper.
package cpu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] IO_BASE_DEF = 16'hC000;
    localparam logic [15:0] IO_MASK_DEF = 16'hF000;
    localparam logic [7:0]  TIMEOUT_DEF = 8'd255;

    function automatic logic is_slow(
        input logic [15:0] addr,
        input logic [15:0] base,
        input logic [15:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl bus bundle: CPU side, fast RAM side and slow I/O side.
// master drives the CPU/memory stimulus, slave is the controller view.
interface cpu_bus_ctrl_if;

    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_ready;

    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    logic        bus_err;

    modport master (
        output cpu_addr, cpu_write, cpu_dout,
        output ram_rdata, ext_rdata, ext_ack,
        input  cpu_din, cpu_ready,
        input  ram_addr, ram_we, ram_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  bus_err
    );

    modport slave (
        input  cpu_addr, cpu_write, cpu_dout,
        input  ram_rdata, ext_rdata, ext_ack,
        output cpu_din, cpu_ready,
        output ram_addr, ram_we, ram_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output bus_err
    );

endinterface

// File: rtl/cpu_bus_timeout.sv
// Slow-bus wait counter with terminal-count compare.
// Saturates at TIMEOUT so it can never wrap while a transfer waits.
module cpu_bus_timeout
    import cpu_bus_ctrl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == TIMEOUT);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: zero-wait fast RAM path plus a stalled slow I/O path.
// Slow accesses go IDLE -> WAIT -> DONE with ack or timeout completion.
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter logic [15:0] IO_MASK = IO_MASK_DEF,
    parameter logic [7:0]  TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           reset_n,
    cpu_bus_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_d;
    logic        slow_sel;
    logic        expired;
    logic        cnt_clr;
    logic        cnt_en;
    logic        ld_req;
    logic        ld_ack;
    logic        ld_to;
    logic        cpu_ready;
    logic        ext_req;
    logic [7:0]  cpu_din;
    logic [7:0]  hold;
    logic [15:0] ext_addr_q;
    logic        ext_we_q;
    logic [7:0]  ext_wdata_q;
    logic        bus_err_q;

    assign slow_sel = is_slow(bus.cpu_addr, IO_BASE, IO_MASK);

    assign bus.ram_addr  = bus.cpu_addr;
    assign bus.ram_wdata = bus.cpu_dout;
    assign bus.ram_we    = bus.cpu_write & ~slow_sel;
    assign bus.cpu_din   = cpu_din;
    assign bus.cpu_ready = cpu_ready;
    assign bus.ext_req   = ext_req;
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_we    = ext_we_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign bus.bus_err   = bus_err_q;

    cpu_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        ld_req    = 1'b0;
        ld_ack    = 1'b0;
        ld_to     = 1'b0;
        cpu_ready = 1'b1;
        ext_req   = 1'b0;
        cpu_din   = bus.ram_rdata;
        unique case (state)
            IDLE: begin
                if (slow_sel) begin
                    cpu_ready = 1'b0;
                    ld_req    = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                ext_req   = 1'b1;
                cpu_ready = 1'b0;
                cnt_en    = 1'b1;
                // a coincident ack beats the timeout
                if (bus.ext_ack) begin
                    ld_ack  = 1'b1;
                    state_d = DONE;
                end else if (expired) begin
                    ld_to   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cpu_din = hold;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_addr_q  <= '0;
            ext_we_q    <= 1'b0;
            ext_wdata_q <= '0;
            hold        <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            bus_err_q <= ld_to;
            if (ld_req) begin
                ext_addr_q  <= bus.cpu_addr;
                ext_we_q    <= bus.cpu_write;
                ext_wdata_q <= bus.cpu_dout;
            end
            if (ld_ack) begin
                hold <= bus.ext_rdata;
            end else if (ld_to) begin
                hold <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl.
// Scoreboard of expected access results, compared when the CPU is released.
module tb_cpu_bus_ctrl;

    localparam int TMO = 255;

    typedef struct {
        logic [15:0] addr;
        bit          we;
        logic [7:0]  wd;
        logic [7:0]  din;
        int          stall;
        int          reqs;
        int          errs;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    exp_t sb[$];

    int         ack_dly;
    logic [7:0] ext_val;
    bit         ack_auto_en;
    logic       ack_auto;
    logic       ack_force;
    int         wcnt;

    cpu_bus_ctrl_if bus ();

    cpu_bus_ctrl #(
        .IO_BASE (16'hC000),
        .IO_MASK (16'hF000),
        .TIMEOUT (8'd255)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_rdata = bus.ram_addr[7:0] + 8'h5A;
    assign bus.ext_ack   = ack_auto | ack_force;
    assign bus.ext_rdata = bus.ext_ack ? ext_val : 8'h00;

    // slow-bus responder: ack in the ack_dly-th request cycle
    always @(negedge clk) begin
        if (ack_auto_en && bus.ext_req) begin
            wcnt     <= wcnt + 1;
            ack_auto <= ((wcnt + 1) == ack_dly);
        end else begin
            wcnt     <= 0;
            ack_auto <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input bit w,
                          input logic [7:0] d, input int dly,
                          input logic [7:0] xval);
        exp_t        e;
        exp_t        o;
        bit          slow;
        bit          got;
        int          stall;
        int          reqs;
        int          errs;
        int          badwe;
        int          unstable;
        logic [7:0]  din;
        logic [15:0] ea;
        logic        ew;
        logic [7:0]  ed;
        logic        rwe;
        logic [7:0]  rwd;
        slow  = ((a & 16'hF000) == 16'hC000);
        e.addr = a;
        e.we   = w;
        e.wd   = d;
        if (slow) begin
            e.din   = (dly == 0) ? 8'hFF : xval;
            e.stall = (dly == 0) ? TMO + 2 : 1 + dly;
            e.reqs  = (dly == 0) ? TMO + 1 : dly;
            e.errs  = (dly == 0) ? 1 : 0;
        end else begin
            e.din   = a[7:0] + 8'h5A;
            e.stall = 0;
            e.reqs  = 0;
            e.errs  = 0;
        end
        sb.push_back(e);
        ack_dly       = dly;
        ext_val       = xval;
        bus.cpu_addr  = a;
        bus.cpu_write = w;
        bus.cpu_dout  = d;
        got = 0; stall = 0; reqs = 0; errs = 0;
        badwe = 0; unstable = 0;
        din = '0; ea = '0; ew = 1'b0; ed = '0; rwe = 1'b0; rwd = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.ext_req) begin
                if (reqs == 0) begin
                    ea = bus.ext_addr;
                    ew = bus.ext_we;
                    ed = bus.ext_wdata;
                end else if (bus.ext_addr != ea || bus.ext_we != ew ||
                             bus.ext_wdata != ed) begin
                    unstable++;
                end
                reqs++;
            end
            if (bus.bus_err) errs++;
            if (slow && bus.ram_we) badwe++;
            if (bus.cpu_ready) begin
                din = bus.cpu_din;
                rwe = bus.ram_we;
                rwd = bus.ram_wdata;
                got = 1;
                break;
            end
            stall++;
        end
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk($sformatf("ready_seen@%h", o.addr), got, 1);
        chk($sformatf("stall@%h", o.addr), stall, o.stall);
        chk($sformatf("reqs@%h", o.addr), reqs, o.reqs);
        chk($sformatf("bus_err@%h", o.addr), errs, o.errs);
        if (!o.we) chk($sformatf("din@%h", o.addr), din, o.din);
        if (slow) begin
            chk($sformatf("ext_addr@%h", o.addr), ea, o.addr);
            chk($sformatf("ext_we@%h", o.addr), ew, o.we);
            if (o.we) chk($sformatf("ext_wdata@%h", o.addr), ed, o.wd);
            chk($sformatf("ram_we_slow@%h", o.addr), badwe, 0);
            chk($sformatf("stable@%h", o.addr), unstable, 0);
        end else if (o.we) begin
            chk($sformatf("ram_we@%h", o.addr), rwe, 1);
            chk($sformatf("ram_wdata@%h", o.addr), rwd, o.wd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_chk         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_write = 1'b0;
        bus.cpu_dout  = 8'h00;
        ack_force     = 1'b0;
        ack_auto_en   = 1'b1;
        ack_dly       = 1;
        ext_val       = 8'h00;
        #3;
        chk("rst_ext_req", bus.ext_req, 0);
        chk("rst_bus_err", bus.bus_err, 0);
        chk("rst_ext_addr", bus.ext_addr, 0);
        chk("rst_ext_we", bus.ext_we, 0);
        chk("rst_ext_wdata", bus.ext_wdata, 0);
        chk("rst_ready", bus.cpu_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        access(16'h0200, 1'b0, 8'h00, 0, 8'h00);
        access(16'h1234, 1'b1, 8'h77, 0, 8'h00);
        access(16'hC010, 1'b0, 8'h00, 2, 8'h3C);
        access(16'hC001, 1'b1, 8'hA5, 1, 8'h11);
        access(16'hC002, 1'b0, 8'h00, 0, 8'h99);
        access(16'hC100, 1'b0, 8'h00, TMO + 1, 8'h42);
        access(16'hC000, 1'b0, 8'h00, 1, 8'h10);
        access(16'hC004, 1'b0, 8'h00, 1, 8'h14);
        access(16'hBFFF, 1'b0, 8'h00, 0, 8'h00);
        access(16'hD000, 1'b1, 8'h3E, 0, 8'h00);
        access(16'hCFFF, 1'b0, 8'h00, 3, 8'hE7);

        // reset in the middle of a wait, then a late ack
        ack_auto_en   = 1'b0;
        bus.cpu_addr  = 16'hC020;
        bus.cpu_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", bus.ext_req, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.ext_req, 0);
        chk("mid_rst_err", bus.bus_err, 0);
        chk("mid_rst_addr", bus.ext_addr, 0);
        bus.cpu_addr = 16'h0300;
        #1;
        chk("mid_rst_ready", bus.cpu_ready, 1);
        ack_force = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_req", bus.ext_req, 0);
            chk("late_ack_err", bus.bus_err, 0);
            chk("late_ack_ready", bus.cpu_ready, 1);
        end
        ack_force   = 1'b0;
        ack_auto_en = 1'b1;
        @(posedge clk);
        #1;
        access(16'hC008, 1'b0, 8'h00, 1, 8'h81);
        access(16'h0042, 1'b0, 8'h00, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
